ifetch_unit: RTL
================

Name: ifetch_unit

Overview:
- Instruction fetch stage directly upstream of the single-cycle MIPS controller/decoder.
- Owns the PC and issues one instruction-memory request at a time over a req/ack handshake.
- Holds the returned word and presents it, with op/funct split out, to decode.
- On retirement, takes the redirect decision (pcsrc, jump) back from the controller and computes the branch or jump target itself.

Parameters:
RESET_PC, 32'h00000000, PC loaded by reset
TIMEOUT, 16, max cycles imem_req may stay high without imem_ack before fault; 0 disables the check

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_req  output  1  instruction memory request
imem_addr  output  32  word address of the request, byte-addressed, [1:0]=00
imem_ack  input  1  memory has valid data on imem_rdata this cycle
imem_rdata  input  32  instruction word
id_ready  input  1  decode/execute consumes the held instruction this cycle
pcsrc  input  1  controller: taken branch for the held instruction
jump  input  1  controller: J for the held instruction
instr  output  32  held instruction
op  output  6  instr[31:26]
funct  output  6  instr[5:0]
instr_valid  output  1  instr/pc/pcplus4 are valid
pc  output  32  address of the held instruction
pcplus4  output  32  pc + 4
retire_count  output  32  count of retired instructions
fault  output  1  sticky fetch-timeout flag

Behaviour:
- States: FETCH, HOLD, FAULT.
- Reset (synchronous, wins over every other input):
  - state=FETCH, pc=RESET_PC, instr=0, timer=0, retire_count=0, fault=0.
  - imem_req is gated low while reset=1.
  - instr_valid=0 in any cycle reset was sampled.
- FETCH:
  - imem_req=1; imem_addr=pc, stable until ack; instr_valid=0.
  - On ack: instr<=imem_rdata, timer<=0, go HOLD.
  - With no ack: timer increments.
  - If TIMEOUT!=0 and timer==TIMEOUT-1 with no ack: go FAULT.
- HOLD:
  - imem_req=0; instr_valid=1; instr, pc, pcplus4 stable.
  - imem_ack is ignored.
  - On id_ready (retire):
    - jump=1: pc <= {pcplus4[31:28], instr[25:0], 2'b00}.
    - Else pcsrc=1: pc <= pcplus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}), modulo 2^32.
    - Else: pc <= pcplus4.
    - retire_count increments, wraps 0xFFFFFFFF to 0.
    - Go FETCH.
  - jump and pcsrc both high: jump wins.
  - pcsrc/jump are sampled only on the retire edge.
- FAULT:
  - imem_req=0, instr_valid=0, fault=1.
  - Only reset exits.
- Latency:
  - Zero-wait memory (ack in the first req cycle) gives instr_valid on the next cycle.
  - With id_ready held high, sustained throughput is 1 instruction per 2 cycles.
- pcplus4 = pc + 4, combinational, wraps modulo 2^32.
- op and funct are combinational slices of instr.
- Reset mid-FETCH drops the request. The memory shares this reset and must discard any outstanding request.
- Ack and reset in the same cycle: reset wins and the data is discarded.

Test Plan:
- Reset, RESET_PC=0, memory acks same cycle, id_ready=1, pcsrc=jump=0 -> imem_addr sequence 0x0,0x4,0x8; instr_valid high every other cycle; retire_count=3 after 6 cycles.
- Ack delayed 3 cycles -> imem_req held high 4 cycles with imem_addr constant; instr_valid rises cycle after ack; op/funct match imem_rdata 0x00A42020 (op=0, funct=0x20).
- Held instr at pc=0x10 is BEQ with imm 0xFFFE, pcsrc=1 -> next imem_addr=0x0C. Same with imm 0x0003 -> 0x20.
- Held instr at pc=0x40 is J 0x0000100 with jump=1 and pcsrc=1 -> next imem_addr=0x400 (jump priority).
- id_ready=0 for 5 cycles in HOLD while imem_ack pulses -> instr, pc, instr_valid unchanged; no imem_req; retire_count unchanged.
- TIMEOUT=16, ack never asserted -> fault=1 after 16 req cycles; imem_req=0; reset restores imem_addr=RESET_PC, fault=0, retire_count=0.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time over req/ack,
// holds it for decode and computes the branch/jump target on retirement.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        id_ready,
    input  logic        pcsrc,
    input  logic        jump,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    output logic [31:0] retire_count,
    output logic        fault
);

    typedef enum logic [1:0] {StFetch, StHold, StFault} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] retire_q, retire_d;

    logic [31:0] pcplus4_w;
    logic [31:0] br_off;
    logic [31:0] jmp_tgt;

    assign pcplus4_w = pc_q + 32'd4;
    assign br_off    = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign jmp_tgt   = {pcplus4_w[31:28], instr_q[25:0], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StFetch;
            pc_q     <= RESET_PC;
            instr_q  <= 32'h0;
            timer_q  <= 32'h0;
            retire_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            timer_q  <= timer_d;
            retire_q <= retire_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        timer_d  = timer_q;
        retire_d = retire_q;
        case (state_q)
            StFetch: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    timer_d = 32'h0;
                    state_d = StHold;
                end else begin
                    timer_d = timer_q + 32'd1;
                    // A zero TIMEOUT disables the watchdog entirely.
                    if ((TIMEOUT != 0) && (timer_q == 32'(TIMEOUT - 1))) begin
                        state_d = StFault;
                    end
                end
            end
            StHold: begin
                if (id_ready) begin
                    if (jump) begin
                        pc_d = jmp_tgt;
                    end else if (pcsrc) begin
                        pc_d = pcplus4_w + br_off;
                    end else begin
                        pc_d = pcplus4_w;
                    end
                    retire_d = retire_q + 32'd1;
                    state_d  = StFetch;
                end
            end
            StFault: ;
            default: state_d = StFetch;
        endcase
    end

    always_comb begin
        imem_req     = (state_q == StFetch) && !reset;
        instr_valid  = (state_q == StHold) && !reset;
        fault        = (state_q == StFault);
        imem_addr    = pc_q;
        instr        = instr_q;
        op           = instr_q[31:26];
        funct        = instr_q[5:0];
        pc           = pc_q;
        pcplus4      = pcplus4_w;
        retire_count = retire_q;
    end

endmodule
